seven_segment_to_binary: RTL



---
 rtl/seven_segment_to_binary.sv | 124 ++++++++++++
 1 files changed

// File: rtl/seven_segment_to_binary.sv
// rtl/seven_segment_to_binary.sv - seven-segment pattern receiver: synchronize, debounce, decode to 0-9
module seven_segment_to_binary #(
   parameter int STABLE_CYCLES = 4
) (
   input  logic       i_Clk,
   input  logic       i_Rst_L,
   input  logic       i_Segment_A,
   input  logic       i_Segment_B,
   input  logic       i_Segment_C,
   input  logic       i_Segment_D,
   input  logic       i_Segment_E,
   input  logic       i_Segment_F,
   input  logic       i_Segment_G,
   output logic [3:0] o_Binary_Number,
   output logic       o_Valid,
   output logic       o_Locked,
   output logic       o_Blank,
   output logic       o_Invalid
);

   typedef enum logic {SETTLING = 1'b0, LOCKED = 1'b1} state_t;

   localparam logic [7:0] LAST_COUNT = 8'(STABLE_CYCLES - 1);

   logic [6:0] r_Sync1_q, r_Sync2_q, r_Prev_q;
   logic [7:0] r_Count_q, r_Count_d;
   state_t     state_q, state_d;
   logic [3:0] bin_q, bin_d;
   logic       valid_q, valid_d;
   logic       blank_q, blank_d;
   logic       invalid_q, invalid_d;
   logic       mismatch;
   logic [3:0] dec_bin;
   logic       dec_blank, dec_invalid;

   assign mismatch = (r_Sync2_q != r_Prev_q);

   // Decode looks at the synchronized pattern; it is only consumed when it equals r_Prev.
   always_comb begin
      dec_bin     = 4'h0;
      dec_blank   = 1'b0;
      dec_invalid = 1'b0;
      case (r_Sync2_q)
         7'h7E: dec_bin = 4'd0;
         7'h30: dec_bin = 4'd1;
         7'h6D: dec_bin = 4'd2;
         7'h79: dec_bin = 4'd3;
         7'h33: dec_bin = 4'd4;
         7'h5B: dec_bin = 4'd5;
         7'h5F: dec_bin = 4'd6;
         7'h70: dec_bin = 4'd7;
         7'h7F: dec_bin = 4'd8;
         7'h7B: dec_bin = 4'd9;
         7'h00: dec_blank = 1'b1;
         default: begin
            dec_bin     = 4'hF;
            dec_invalid = 1'b1;
         end
      endcase
   end

   always_comb begin
      state_d   = state_q;
      r_Count_d = r_Count_q;
      valid_d   = 1'b0;
      bin_d     = bin_q;
      blank_d   = blank_q;
      invalid_d = invalid_q;
      case (state_q)
         SETTLING: begin
            if (mismatch) begin
               r_Count_d = 8'd0;
            end else if (r_Count_q == LAST_COUNT) begin
               state_d   = LOCKED;
               valid_d   = 1'b1;
               bin_d     = dec_bin;
               blank_d   = dec_blank;
               invalid_d = dec_invalid;
            end else begin
               r_Count_d = r_Count_q + 8'd1;
            end
         end
         LOCKED: begin
            if (mismatch) begin
               state_d   = SETTLING;
               r_Count_d = 8'd0;
            end
         end
         default: state_d = SETTLING;
      endcase
   end

   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         r_Sync1_q <= 7'h00;
         r_Sync2_q <= 7'h00;
         r_Prev_q  <= 7'h00;
         r_Count_q <= 8'd0;
         state_q   <= SETTLING;
         bin_q     <= 4'h0;
         valid_q   <= 1'b0;
         blank_q   <= 1'b0;
         invalid_q <= 1'b0;
      end else begin
         r_Sync1_q <= {i_Segment_A, i_Segment_B, i_Segment_C, i_Segment_D,
                       i_Segment_E, i_Segment_F, i_Segment_G};
         r_Sync2_q <= r_Sync1_q;
         r_Prev_q  <= r_Sync2_q;
         r_Count_q <= r_Count_d;
         state_q   <= state_d;
         bin_q     <= bin_d;
         valid_q   <= valid_d;
         blank_q   <= blank_d;
         invalid_q <= invalid_d;
      end
   end

   assign o_Binary_Number = bin_q;
   assign o_Valid         = valid_q;
   assign o_Locked        = (state_q == LOCKED);
   assign o_Blank         = blank_q;
   assign o_Invalid       = invalid_q;

endmodule
